// File: rtl/stack_multi_op_sequencer_pkg.sv
// Shared types and opcode constants for the stack multi-op sequencer.
package stack_multi_op_sequencer_pkg;

  typedef enum logic [1:0] {
    UOP_PASS   = 2'd0,
    UOP_STORE  = 2'd1,
    UOP_LOAD   = 2'd2,
    UOP_SP_ADJ = 2'd3
  } uop_kind_e;

  localparam logic [6:0] PUSH_OPCODE = 7'b1011010;
  localparam logic [6:0] POP_OPCODE  = 7'b1011110;

  typedef enum logic {
    SEQ_IDLE   = 1'b0,
    SEQ_EXPAND = 1'b1
  } seq_state_e;

endpackage

// File: rtl/stack_multi_op_sequencer_reg_list_picker.sv
// Combinational register-list picker: lowest set index, remaining mask,
// population count and empty flag.
module reg_list_picker #(
  parameter int MASK_W = 9,
  parameter int IDX_W  = $clog2(MASK_W),
  parameter int CNT_W  = $clog2(MASK_W + 1)
) (
  input  logic [MASK_W-1:0] mask,
  output logic [IDX_W-1:0]  low_idx,
  output logic [MASK_W-1:0] mask_rest,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  always_comb begin
    low_idx = '0;
    count   = '0;
    // Scanning downward leaves the lowest set bit as the final winner.
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) low_idx = IDX_W'(i);
    end
    for (int i = 0; i < MASK_W; i++) begin
      count = count + CNT_W'(mask[i]);
    end
  end

  assign mask_rest = mask & (mask - MASK_W'(1));
  assign empty     = ~|mask;

endmodule

// File: rtl/stack_multi_op_sequencer.sv
// Thumb PUSH/POP expander: one micro-op per listed register plus SP adjust.
// Optional stall counter enabled by defining SEQ_STALL_CNT_EN.
module stack_multi_op_sequencer
  import stack_multi_op_sequencer_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int INSTR_W    = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int LIST_W     = 8,
  parameter int SP_REG     = 13,
  parameter int LR_REG     = 14,
  parameter int PC_REG     = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [INSTR_W-1:0]    instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic                  flush_i,
  output logic                  uop_valid_o,
  input  logic                  uop_ready_i,
  output logic [1:0]            uop_kind_o,
  output logic [INSTR_W-1:0]    uop_instr_o,
  output logic [ADDR_WIDTH-1:0] uop_reg_o,
  output logic [WORD-1:0]       uop_offset_o,
  output logic                  uop_last_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int MASK_W = LIST_W + 1;
  localparam int IDX_W  = $clog2(MASK_W);
  localparam int CNT_W  = $clog2(MASK_W + 1);

  seq_state_e        state_p1;
  logic [MASK_W-1:0] mask_p1;
  logic [CNT_W-1:0]  idx_p1;
  logic [CNT_W-1:0]  n_p1;
  logic              push_p1;

  logic              is_push, is_pop, accept;
  logic [MASK_W-1:0] dec_mask, pick_in, pick_rest;
  logic [IDX_W-1:0]  pick_idx;
  logic [CNT_W-1:0]  pick_cnt;
  logic              pick_empty;

  function automatic logic [ADDR_WIDTH-1:0] idx_to_reg(input logic [IDX_W-1:0] idx,
                                                       input logic push);
    if (idx == IDX_W'(LIST_W)) return push ? ADDR_WIDTH'(LR_REG) : ADDR_WIDTH'(PC_REG);
    return ADDR_WIDTH'(idx);
  endfunction

  // PUSH stores sit below the pre-instruction SP; POP loads sit at and above it.
  function automatic logic signed [WORD-1:0] reg_offset(input logic push,
                                                        input logic [CNT_W-1:0] k,
                                                        input logic [CNT_W-1:0] n);
    logic signed [WORD-1:0] ks, ns;
    ks = signed'(WORD'(k));
    ns = signed'(WORD'(n));
    return push ? ((ks - ns) <<< 2) : (ks <<< 2);
  endfunction

  function automatic logic signed [WORD-1:0] sp_offset(input logic push,
                                                       input logic [CNT_W-1:0] n);
    logic signed [WORD-1:0] ns;
    ns = signed'(WORD'(n));
    return push ? -(ns <<< 2) : (ns <<< 2);
  endfunction

  assign is_push  = (instr_i[15:9] == PUSH_OPCODE);
  assign is_pop   = (instr_i[15:9] == POP_OPCODE);
  assign dec_mask = {instr_i[8], instr_i[LIST_W-1:0]};
  assign pick_in  = (state_p1 == SEQ_IDLE) ? dec_mask : mask_p1;

  assign instr_ready_o = !flush_i && (state_p1 == SEQ_IDLE) && (!uop_valid_o || uop_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  reg_list_picker #(
    .MASK_W (MASK_W),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_picker (
    .mask      (pick_in),
    .low_idx   (pick_idx),
    .mask_rest (pick_rest),
    .count     (pick_cnt),
    .empty     (pick_empty)
  );

  // Output stage: flush beats transfer beats accept.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_p1     <= SEQ_IDLE;
      mask_p1      <= '0;
      idx_p1       <= '0;
      n_p1         <= '0;
      push_p1      <= 1'b0;
      uop_valid_o  <= 1'b0;
      uop_kind_o   <= UOP_PASS;
      uop_instr_o  <= '0;
      uop_reg_o    <= '0;
      uop_offset_o <= '0;
      uop_last_o   <= 1'b0;
    end else if (flush_i) begin
      uop_valid_o <= 1'b0;
      state_p1    <= SEQ_IDLE;
      mask_p1     <= '0;
      idx_p1      <= '0;
    end else if (state_p1 == SEQ_EXPAND) begin
      if (uop_ready_i) begin
        uop_valid_o <= 1'b1;
        if (pick_empty) begin
          uop_kind_o   <= UOP_SP_ADJ;
          uop_reg_o    <= ADDR_WIDTH'(SP_REG);
          uop_offset_o <= sp_offset(push_p1, n_p1);
          uop_last_o   <= 1'b1;
          state_p1     <= SEQ_IDLE;
          idx_p1       <= '0;
        end else begin
          uop_kind_o   <= push_p1 ? UOP_STORE : UOP_LOAD;
          uop_reg_o    <= idx_to_reg(pick_idx, push_p1);
          uop_offset_o <= reg_offset(push_p1, idx_p1, n_p1);
          uop_last_o   <= 1'b0;
          mask_p1      <= pick_rest;
          idx_p1       <= idx_p1 + CNT_W'(1);
        end
      end
    end else if (accept) begin
      uop_valid_o <= 1'b1;
      uop_instr_o <= instr_i;
      if (!is_push && !is_pop) begin
        uop_kind_o   <= UOP_PASS;
        uop_reg_o    <= '0;
        uop_offset_o <= '0;
        uop_last_o   <= 1'b1;
      end else if (pick_empty) begin
        uop_kind_o   <= UOP_SP_ADJ;
        uop_reg_o    <= ADDR_WIDTH'(SP_REG);
        uop_offset_o <= '0;
        uop_last_o   <= 1'b1;
      end else begin
        uop_kind_o   <= is_push ? UOP_STORE : UOP_LOAD;
        uop_reg_o    <= idx_to_reg(pick_idx, is_push);
        uop_offset_o <= reg_offset(is_push, '0, pick_cnt);
        uop_last_o   <= 1'b0;
        mask_p1      <= pick_rest;
        idx_p1       <= CNT_W'(1);
        n_p1         <= pick_cnt;
        push_p1      <= is_push;
        state_p1     <= SEQ_EXPAND;
      end
    end else if (uop_ready_i) begin
      uop_valid_o <= 1'b0;
    end
  end

`ifdef SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cnt_p1 <= '0;
    end else if (instr_valid_i && !instr_ready_o) begin
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign stall_cnt_o = stall_cnt_p1;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stack_multi_op_sequencer.sv
// Self-checking bench for stack_multi_op_sequencer: list-level model plus literal tables.
module tb_stack_multi_op_sequencer;

  logic        clk;
  logic        reset_i;
  logic [15:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic        uop_valid_o;
  logic        uop_ready_i;
  logic [1:0]  uop_kind_o;
  logic [15:0] uop_instr_o;
  logic [3:0]  uop_reg_o;
  logic [31:0] uop_offset_o;
  logic        uop_last_o;
  logic [31:0] stall_cnt_o;

  stack_multi_op_sequencer dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .flush_i       (flush_i),
    .uop_valid_o   (uop_valid_o),
    .uop_ready_i   (uop_ready_i),
    .uop_kind_o    (uop_kind_o),
    .uop_instr_o   (uop_instr_o),
    .uop_reg_o     (uop_reg_o),
    .uop_offset_o  (uop_offset_o),
    .uop_last_o    (uop_last_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  r;
    logic [31:0] off;
    logic        last;
    logic [15:0] instr;
  } uop_t;

  uop_t        exp_q[$];
  uop_t        tlog[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] stall_exp = 0;
  logic        exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected micro-op list for one instruction, built from the list semantics.
  task automatic expand(input logic [15:0] ins);
    int   regs[$];
    int   n;
    bit   push, pop;
    uop_t u;
    push = (ins[15:9] == 7'b1011010);
    pop  = (ins[15:9] == 7'b1011110);
    u.instr = ins;
    if (!push && !pop) begin
      u.kind = 2'd0; u.r = 4'd0; u.off = 32'd0; u.last = 1'b1;
      exp_q.push_back(u);
      return;
    end
    for (int i = 0; i < 8; i++) if (ins[i]) regs.push_back(i);
    if (ins[8]) regs.push_back(push ? 14 : 15);
    n = regs.size();
    for (int k = 0; k < n; k++) begin
      u.kind = push ? 2'd1 : 2'd2;
      u.r    = 4'(regs[k]);
      u.off  = push ? 32'(4 * k - 4 * n) : 32'(4 * k);
      u.last = 1'b0;
      exp_q.push_back(u);
    end
    u.kind = 2'd3; u.r = 4'd13; u.last = 1'b1;
    u.off  = push ? 32'(-4 * n) : 32'(4 * n);
    exp_q.push_back(u);
  endtask

  always @(negedge clk) begin
    if (!reset_i) begin
      chk("rst_uop_valid", uop_valid_o, 0);
      chk("rst_uop_kind", uop_kind_o, 0);
      chk("rst_uop_instr", uop_instr_o, 0);
      chk("rst_uop_reg", uop_reg_o, 0);
      chk("rst_uop_offset", uop_offset_o, 0);
      chk("rst_uop_last", uop_last_o, 0);
      chk("rst_stall_cnt", stall_cnt_o, 0);
      exp_q.delete();
      stall_exp = 0;
    end else begin
      exp_ready = !flush_i && (exp_q.size() <= 1) && (exp_q.size() == 0 || uop_ready_i);
      chk("instr_ready", instr_ready_o, exp_ready);
      chk("uop_valid", uop_valid_o, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("uop_kind", uop_kind_o, exp_q[0].kind);
        chk("uop_instr", uop_instr_o, exp_q[0].instr);
        chk("uop_reg", uop_reg_o, exp_q[0].r);
        chk("uop_offset", uop_offset_o, exp_q[0].off);
        chk("uop_last", uop_last_o, exp_q[0].last);
      end
      chk("stall_cnt", stall_cnt_o, stall_exp);
      if (uop_valid_o && uop_ready_i && !flush_i)
        tlog.push_back('{uop_kind_o, uop_reg_o, uop_offset_o, uop_last_o, uop_instr_o});
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && uop_ready_i) void'(exp_q.pop_front());
        if (instr_valid_i && exp_ready) expand(instr_i);
      end
`ifdef SEQ_STALL_CNT_EN
      if (instr_valid_i && !exp_ready && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 1;
`endif
    end
  end

  task automatic send(input logic [15:0] ins, output int waited);
    bit acc;
    acc = 0;
    waited = 0;
    instr_i = ins;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clk);
      if (instr_ready_o) acc = 1;
      else waited++;
      @(posedge clk); #1;
    end
    instr_valid_i = 1'b0;
    instr_i = 16'h0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!uop_valid_o) done = 1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic expect_uop(input int i, input logic [1:0] k, input logic [3:0] r,
                            input int off, input logic l);
    if (i < tlog.size()) begin
      chk($sformatf("lit_kind[%0d]", i), tlog[i].kind, k);
      chk($sformatf("lit_reg[%0d]", i), tlog[i].r, r);
      chk($sformatf("lit_off[%0d]", i), tlog[i].off, 32'(off));
      chk($sformatf("lit_last[%0d]", i), tlog[i].last, l);
    end else begin
      chk($sformatf("lit_missing[%0d]", i), 0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int w, w2;

  initial begin
    reset_i = 1'b0;
    instr_i = 16'h0;
    instr_valid_i = 1'b0;
    flush_i = 1'b0;
    uop_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_i = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_valid", uop_valid_o, 0);
    chk("post_reset_ready", instr_ready_o, 1);

    // PUSH {r0,r2,LR} followed immediately by POP {r1,PC}
    tlog.delete();
    send(16'hB505, w);
    send(16'hBD02, w2);
    chk("push_stall_cycles", w2, 3);
`ifdef SEQ_STALL_CNT_EN
    chk("stall_cnt_after_push", stall_cnt_o, 3);
`endif
    drain();
    chk("push_pop_count", tlog.size(), 7);
    expect_uop(0, 2'd1, 4'd0, -12, 1'b0);
    expect_uop(1, 2'd1, 4'd2, -8, 1'b0);
    expect_uop(2, 2'd1, 4'd14, -4, 1'b0);
    expect_uop(3, 2'd3, 4'd13, -12, 1'b1);
    expect_uop(4, 2'd2, 4'd1, 0, 1'b0);
    expect_uop(5, 2'd2, 4'd15, 4, 1'b0);
    expect_uop(6, 2'd3, 4'd13, 8, 1'b1);

    // Pass-through held under backpressure
    tlog.delete();
    uop_ready_i = 1'b0;
    send(16'h1888, w);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("held_pass_instr", uop_instr_o, 16'h1888);
    uop_ready_i = 1'b1;
    drain();
    chk("pass_count", tlog.size(), 1);
    expect_uop(0, 2'd0, 4'd0, 0, 1'b1);

    // Empty PUSH list, then back-to-back accept
    tlog.delete();
    send(16'hB400, w);
    send(16'h1888, w2);
    chk("b2b_wait", w2, 0);
    drain();
    chk("empty_count", tlog.size(), 2);
    expect_uop(0, 2'd3, 4'd13, 0, 1'b1);
    expect_uop(1, 2'd0, 4'd0, 0, 1'b1);

    // Flush after the second transfer of PUSH {r0-r7,LR}
    tlog.delete();
    send(16'hB5FF, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_valid", uop_valid_o, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    send(16'h1888, w);
    drain();
    chk("flush_count", tlog.size(), 3);
    expect_uop(0, 2'd1, 4'd0, -36, 1'b0);
    expect_uop(1, 2'd1, 4'd1, -32, 1'b0);
    expect_uop(2, 2'd0, 4'd0, 0, 1'b1);

    // Asynchronous reset in the middle of an expansion
    send(16'hB5FF, w);
    @(posedge clk); #2;
    reset_i = 1'b0;
    #1;
    chk("async_rst_valid", uop_valid_o, 0);
    chk("async_rst_offset", uop_offset_o, 0);
    chk("async_rst_kind", uop_kind_o, 0);
    chk("async_rst_stall", stall_cnt_o, 0);
    @(posedge clk); #2;
    reset_i = 1'b1;
    @(posedge clk); #1;
    tlog.delete();
    send(16'hBD02, w);
    chk("after_rst_wait", w, 0);
    drain();
    chk("after_rst_count", tlog.size(), 3);
    expect_uop(0, 2'd2, 4'd1, 0, 1'b0);
    expect_uop(1, 2'd2, 4'd15, 4, 1'b0);
    expect_uop(2, 2'd3, 4'd13, 8, 1'b1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
